// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: fetch PC sequencing, imem request/response handshake and prefetch FIFO feeding the decoder.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          imem_req,
  output logic [31:0]                   imem_addr,
  input  logic                          imem_gnt,
  input  logic                          imem_rvalid,
  input  logic [31:0]                   imem_rdata,
  input  logic                          redirect,
  input  logic [31:0]                   redirect_pc,
  input  logic                          stall,
  output logic                          push_ops,
  output logic [31:0]                   opcode,
  output logic [31:0]                   pc_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] BASE_PC = {RESET_PC[31:2], 2'b00};
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state;
  logic [31:0] fetch_pc, out_pc, target;
  logic [AW:0] outstanding, drop_cnt, drop_next;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW+1:0] credit;
  logic gnt, push, pop;
  assign imem_addr = fetch_pc;
  always_comb begin
    credit = {1'b0, outstanding} + {1'b0, fifo_count};
    imem_req = !reset && state == RUN && !redirect && credit < (AW+2)'(FIFO_DEPTH);
    gnt = imem_req && imem_gnt;
    push = state == RUN && imem_rvalid && !redirect;
    pop = fifo_count != '0 && !stall && !redirect;
    target = {redirect_pc[31:2], 2'b00};
    // a grant coinciding with a redirect is still in flight and must be dropped later
    drop_next = state == RUN ? outstanding + (AW+1)'(imem_gnt) - (AW+1)'(imem_rvalid)
                             : drop_cnt - (AW+1)'(imem_rvalid);
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= imem_rdata;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      fetch_pc    <= BASE_PC;
      out_pc      <= BASE_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      push_ops    <= 1'b0;
      opcode      <= '0;
      pc_out      <= BASE_PC;
    end else begin
      push_ops <= pop;
      if (pop) begin
        opcode <= mem[rd_ptr];
        pc_out <= out_pc;
      end
      if (redirect) begin
        fetch_pc    <= target;
        out_pc      <= target;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        fifo_count  <= '0;
        outstanding <= '0;
        drop_cnt    <= drop_next;
        state       <= drop_next == '0 ? RUN : DRAIN;
      end else begin
        if (gnt) fetch_pc <= fetch_pc + 32'd4;
        if (pop) begin
          out_pc <= out_pc + 32'd4;
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push) wr_ptr <= wr_ptr + 1'b1;
        fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
        if (state == RUN) outstanding <= outstanding + (AW+1)'(gnt) - (AW+1)'(imem_rvalid);
        else begin
          drop_cnt <= drop_next;
          if (drop_next == '0) state <= RUN;
        end
      end
    end
  end
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb_riscv_fetch_unit: directed checks of fetch, stall, redirect/drain, grant hold-off and mid-stream reset.
module tb_riscv_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic imem_req, imem_gnt, imem_rvalid, redirect, stall, push_ops;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, opcode, pc_out;
  logic [2:0] fifo_count;
  logic gnt_en = 1'b1;
  logic force_gnt = 1'b0;
  int lat = 1;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int n_drop, exp_drop;
  logic [31:0] exp_pc = 32'h100;
  logic [31:0] q_addr [$];
  int q_due [$];

  riscv_fetch_unit #(.RESET_PC(32'h100), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .push_ops(push_ops), .opcode(opcode), .pc_out(pc_out), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  assign imem_gnt = (imem_req & gnt_en) | force_gnt;

  // in-order memory: a grant in cycle c returns 0x13+addr in cycle c+lat
  always @(posedge clk) begin
    if (reset) begin
      q_addr.delete();
      q_due.delete();
    end else begin
      if (imem_rvalid && q_addr.size() > 0) begin
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (imem_gnt) begin
        q_addr.push_back(imem_addr);
        q_due.push_back(cyc + lat);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    imem_rvalid = !reset && q_addr.size() > 0 && q_due[0] <= cyc;
    imem_rdata  = imem_rvalid ? q_addr[0] + 32'h13 : 32'h0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // scoreboard: every pushed instruction must be the next PC of the current stream
  always @(negedge clk)
    if (push_ops) begin
      check("push_pc", pc_out, exp_pc);
      check("push_op", opcode, exp_pc + 32'h13);
      exp_pc = exp_pc + 32'd4;
    end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_push(input string tag, input logic [31:0] pc);
    for (int i = 0; i < 40 && !push_ops; i++) step();
    check({tag, "_push"}, {31'd0, push_ops}, 32'd1);
    check({tag, "_pc"}, pc_out, pc);
  endtask

  initial begin
    redirect = 1'b0;
    redirect_pc = 32'h0;
    stall = 1'b0;
    step();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h100);
    check("rst_push", {31'd0, push_ops}, 32'd0);
    check("rst_opcode", opcode, 32'h0);
    check("rst_pc_out", pc_out, 32'h100);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("addr0", imem_addr, 32'h100);
    step();
    check("addr1", imem_addr, 32'h104);
    step();
    check("addr2", imem_addr, 32'h108);
    wait_push("stream", 32'h100);
    repeat (10) step();

    stall = 1'b1;
    repeat (10) step();
    check("stall_count", {29'd0, fifo_count}, 32'd4);
    check("stall_req", {31'd0, imem_req}, 32'd0);
    check("stall_push", {31'd0, push_ops}, 32'd0);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("release_push", {31'd0, push_ops}, 32'd1);
    end
    repeat (6) step();

    stall = 1'b1;
    repeat (8) step();
    check("refill_count", {29'd0, fifo_count}, 32'd4);
    lat = 3;
    redirect = 1'b1;
    redirect_pc = 32'h1000;
    stall = 1'b0;
    step();
    redirect = 1'b0;
    repeat (3) step();
    n_drop = int'(imem_rvalid);
    redirect = 1'b1;
    redirect_pc = 32'h2003;
    step();
    redirect = 1'b0;
    exp_pc = 32'h2000;
    check("drain_state", 32'(dut.state), 32'd1);
    check("drain_cnt", 32'(dut.drop_cnt), 32'd2);
    check("drain_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 20 && !imem_req; i++) begin
      n_drop += int'(imem_rvalid);
      step();
    end
    check("dropped", n_drop, 32'd3);
    check("resume_req", {31'd0, imem_req}, 32'd1);
    check("resume_addr", imem_addr, 32'h2000);
    wait_push("redir", 32'h2000);

    lat = 1;
    repeat (10) step();
    for (int i = 0; i < 20 && !(imem_rvalid && imem_req); i++) step();
    check("gnt_rv_ready", {31'd0, imem_rvalid && imem_req}, 32'd1);
    exp_drop = q_addr.size();
    redirect = 1'b1;
    redirect_pc = 32'h3000;
    force_gnt = 1'b1;
    step();
    redirect = 1'b0;
    force_gnt = 1'b0;
    exp_pc = 32'h3000;
    check("gnt_rv_drop", 32'(dut.drop_cnt), exp_drop);
    wait_push("gnt_rv", 32'h3000);

    redirect = 1'b1;
    redirect_pc = 32'h4000;
    gnt_en = 1'b0;
    step();
    redirect = 1'b0;
    exp_pc = 32'h4000;
    for (int i = 0; i < 20 && !imem_req; i++) step();
    for (int i = 0; i < 5; i++) begin
      check("hold_req", {31'd0, imem_req}, 32'd1);
      check("hold_addr", imem_addr, 32'h4000);
      step();
    end
    check("hold_fetch_pc", dut.fetch_pc, 32'h4000);
    gnt_en = 1'b1;
    wait_push("hold", 32'h4000);

    redirect = 1'b1;
    redirect_pc = 32'h5000;
    stall = 1'b1;
    step();
    redirect = 1'b0;
    exp_pc = 32'h5000;
    for (int i = 0; i < 20 && fifo_count != 3'd3; i++) step();
    check("pre_rst_count", {29'd0, fifo_count}, 32'd3);
    reset = 1'b1;
    #1;
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_addr", imem_addr, 32'h100);
    check("mid_rst_push", {31'd0, push_ops}, 32'd0);
    check("mid_rst_opcode", opcode, 32'h0);
    check("mid_rst_pc_out", pc_out, 32'h100);
    check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
    step();
    step();
    reset = 1'b0;
    stall = 1'b0;
    exp_pc = 32'h100;
    #1;
    check("restart_req", {31'd0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, 32'h100);
    wait_push("restart", 32'h100);
    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end
endmodule
